// File: rtl/stack_engine.sv
// rtl/stack_engine.sv - multi-cycle PUSH/POP/CALL/RET sequencer between decode and the register bank
//
// Purpose:
//   Accepts one stack command in IDLE and performs a single data-memory
//   access (MEM).  It then issues one-cycle write strobes (WB): an SP write,
//   a GPR write for POP, and a PC load for CALL and RET.
//
// Optional feature:
//   STACK_BOUNDS_CHECK_EN - when defined, commands that would overflow past
//   STACK_LIMIT or underflow past STACK_BASE are rejected at accept.  They
//   produce a fault/done pulse with no memory access and no writes.  When the
//   macro is undefined, fault is tied 0 and SP arithmetic wraps.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_op                     0 PUSH, 1 POP, 2 CALL, 3 RET
//   cmd_data/target/dr         push value or return address / call target / pop dest
//   sp_in, read_sp             SP from the bank read port, SP select for that port
//   mem_req/we/addr/wdata      memory request, held until mem_ack
//   mem_rdata, mem_ack         read data and completion
//   write_sp, sp_out           SP write strobe and value
//   write_reg, reg_dr/reg_data GPR write strobe, register, data (POP)
//   pc_load, pc_out            PC load strobe and value (CALL/RET)
//   done, fault                completion pulse, bounds fault pulse

module stack_engine #(
    parameter int                DATA_W      = 32,
    parameter int                SP_STEP     = 1,
    parameter logic [DATA_W-1:0] STACK_BASE  = DATA_W'(32'h000003FF),
    parameter logic [DATA_W-1:0] STACK_LIMIT = DATA_W'(32'h00000300)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [DATA_W-1:0] cmd_target,
    input  logic [4:0]        cmd_dr,
    input  logic [DATA_W-1:0] sp_in,
    output logic              read_sp,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              write_sp,
    output logic [DATA_W-1:0] sp_out,
    output logic              write_reg,
    output logic [4:0]        reg_dr,
    output logic [DATA_W-1:0] reg_data,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_out,
    output logic              done,
    output logic              fault
);

    localparam logic [1:0] OP_PUSH = 2'd0;
    localparam logic [1:0] OP_POP  = 2'd1;
    localparam logic [1:0] OP_CALL = 2'd2;
    localparam logic [1:0] OP_RET  = 2'd3;

    localparam logic [DATA_W-1:0] STEP = DATA_W'(SP_STEP);

    typedef enum logic [1:0] {IDLE, MEM, WB} state_t;

    state_t            state_q;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] new_sp_q, target_q;
    logic [4:0]        dr_q;

    logic              mem_req_q, mem_we_q, write_sp_q, write_reg_q, pc_load_q, done_q, fault_q;
    logic [DATA_W-1:0] mem_addr_q, mem_wdata_q, sp_out_q, reg_data_q, pc_out_q;
    logic [4:0]        reg_dr_q;

    // op[0]==0 is a store (PUSH/CALL): pre-decrement, write at the new SP.
    // op[0]==1 is a load (POP/RET): read at the current SP, post-increment.
    logic              is_load;
    logic [DATA_W-1:0] new_sp_d, mem_addr_d;
    assign is_load    = cmd_op[0];
    assign new_sp_d   = is_load ? (sp_in + STEP) : (sp_in - STEP);
    assign mem_addr_d = is_load ? sp_in : (sp_in - STEP);

    // Bounds are compared one bit wider so a decrement below zero or an
    // increment past the top cannot wrap into the legal range.
    logic [DATA_W:0] sp_ext;
    logic            overflow, underflow, bounds_err, accept_fault;
    assign sp_ext     = {1'b0, sp_in};
    assign overflow   = sp_ext < ({1'b0, STACK_LIMIT} + {1'b0, STEP});
    assign underflow  = (sp_ext + {1'b0, STEP}) > {1'b0, STACK_BASE};
    assign bounds_err = is_load ? underflow : overflow;

`ifdef STACK_BOUNDS_CHECK_EN
    assign accept_fault = bounds_err;
`else
    logic unused_bounds;
    assign unused_bounds = bounds_err;
    assign accept_fault  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= OP_PUSH;
            new_sp_q    <= '0;
            target_q    <= '0;
            dr_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            write_sp_q  <= 1'b0;
            sp_out_q    <= '0;
            write_reg_q <= 1'b0;
            reg_dr_q    <= '0;
            reg_data_q  <= '0;
            pc_load_q   <= 1'b0;
            pc_out_q    <= '0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            // Strobes are single-cycle: cleared unless re-armed below.
            write_sp_q  <= 1'b0;
            write_reg_q <= 1'b0;
            pc_load_q   <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q     <= cmd_op;
                        target_q <= cmd_target;
                        dr_q     <= cmd_dr;
                        new_sp_q <= new_sp_d;
                        if (accept_fault) begin
                            // Reuse WB with only fault/done raised.
                            state_q <= WB;
                            fault_q <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= MEM;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= ~is_load;
                            mem_addr_q  <= mem_addr_d;
                            mem_wdata_q <= cmd_data;
                        end
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        state_q    <= WB;
                        mem_req_q  <= 1'b0;
                        write_sp_q <= 1'b1;
                        sp_out_q   <= new_sp_q;
                        done_q     <= 1'b1;
                        case (op_q)
                            OP_POP: begin
                                write_reg_q <= 1'b1;
                                reg_dr_q    <= dr_q;
                                reg_data_q  <= mem_rdata;
                            end
                            OP_CALL: begin
                                pc_load_q <= 1'b1;
                                pc_out_q  <= target_q;
                            end
                            OP_RET: begin
                                pc_load_q <= 1'b1;
                                pc_out_q  <= mem_rdata;
                            end
                            default: ;
                        endcase
                    end
                end
                WB:      state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign read_sp   = (state_q == IDLE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign write_sp  = write_sp_q;
    assign sp_out    = sp_out_q;
    assign write_reg = write_reg_q;
    assign reg_dr    = reg_dr_q;
    assign reg_data  = reg_data_q;
    assign pc_load   = pc_load_q;
    assign pc_out    = pc_out_q;
    assign done      = done_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_stack_engine.sv
// tb/tb_stack_engine.sv - scoreboard bench for stack_engine
module tb_stack_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [31:0] cmd_data = '0, cmd_target = '0, sp_in = '0;
    logic [4:0]  cmd_dr = '0;
    logic        read_sp, mem_req, mem_we, mem_ack = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic        write_sp, write_reg, pc_load, done, fault;
    logic [31:0] sp_out, reg_data, pc_out;
    logic [4:0]  reg_dr;

    stack_engine dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_target(cmd_target), .cmd_dr(cmd_dr),
        .sp_in(sp_in), .read_sp(read_sp), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .write_sp(write_sp), .sp_out(sp_out), .write_reg(write_reg), .reg_dr(reg_dr),
        .reg_data(reg_data), .pc_load(pc_load), .pc_out(pc_out), .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_t;

    typedef struct {
        logic        wsp;
        logic [31:0] sp;
        logic        wreg;
        logic [4:0]  dr;
        logic [31:0] rd;
        logic        pcl;
        logic [31:0] pc;
        logic        flt;
        int          lat;
    } wb_t;

    mem_t memq[$];
    wb_t  wbq[$];
    int   accept_cyc = 0;

    // Memory model: acks after ack_delay wait cycles, or follows manual_ack.
    int          ack_delay = 0, wait_cnt = 0;
    logic        resp_en = 1'b1, manual_ack = 1'b0;
    logic [31:0] rd_value = '0;

    always begin
        @(posedge clk);
        #2;
        mem_rdata = rd_value;
        if (!resp_en) begin
            mem_ack = manual_ack;
        end else if (mem_req) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
            end else begin
                mem_ack  = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    // Monitor: pops expectations whenever the DUT presents a transaction.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_req && mem_ack) begin
                if (memq.size() == 0) chk("unexpected_mem_access", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    mem_t e;
                    e = memq.pop_front();
                    chk("mem_we", 64'(mem_we), 64'(e.we));
                    chk("mem_addr", 64'(mem_addr), 64'(e.addr));
                    if (e.we) chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
                end
            end
            if (done) begin
                if (wbq.size() == 0) chk("unexpected_done", 64'(done), 64'd0);
                else begin
                    wb_t w;
                    w = wbq.pop_front();
                    chk("write_sp", 64'(write_sp), 64'(w.wsp));
                    if (w.wsp) chk("sp_out", 64'(sp_out), 64'(w.sp));
                    chk("write_reg", 64'(write_reg), 64'(w.wreg));
                    if (w.wreg) begin
                        chk("reg_dr", 64'(reg_dr), 64'(w.dr));
                        chk("reg_data", 64'(reg_data), 64'(w.rd));
                    end
                    chk("pc_load", 64'(pc_load), 64'(w.pcl));
                    if (w.pcl) chk("pc_out", 64'(pc_out), 64'(w.pc));
                    chk("fault", 64'(fault), 64'(w.flt));
                    chk("latency", 64'(cyc - accept_cyc), 64'(w.lat));
                end
            end
            if ((write_sp || write_reg || pc_load || fault) && !done)
                chk("strobe_without_done", 64'({write_sp, write_reg, pc_load, fault}), 64'd0);
        end
    end

    task automatic exp_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        mem_t e;
        e.we = we; e.addr = addr; e.wdata = wdata;
        memq.push_back(e);
    endtask

    task automatic exp_wb(input logic wsp, input logic [31:0] sp, input logic wreg, input logic [4:0] dr,
                          input logic [31:0] rd, input logic pcl, input logic [31:0] pc,
                          input logic flt, input int lat);
        wb_t w;
        w.wsp = wsp; w.sp = sp; w.wreg = wreg; w.dr = dr; w.rd = rd;
        w.pcl = pcl; w.pc = pc; w.flt = flt; w.lat = lat;
        wbq.push_back(w);
    endtask

    // Presents a command and returns just after the accept edge; hold keeps cmd_valid high.
    task automatic issue(input logic [1:0] op, input logic [31:0] data, input logic [31:0] target,
                         input logic [4:0] dr, input logic [31:0] sp, input bit hold);
        bit got;
        got = 1'b0;
        cmd_op = op; cmd_data = data; cmd_target = target; cmd_dr = dr; sp_in = sp;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1'b1;
                accept_cyc = cyc;
            end
        end
        if (!got) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && wbq.size() > 0; i++) @(negedge clk);
        chk("drain_pending", 64'(wbq.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_read_sp", 64'(read_sp), 64'd1);
        chk("rst_strobes", 64'({mem_req, write_sp, write_reg, pc_load, done, fault}), 64'd0);
        chk("rst_data", 64'(mem_addr | mem_wdata | sp_out | reg_data | pc_out | 32'(reg_dr)), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        @(posedge clk);
        #1;

        // PUSH with a 2-cycle ack wait
        ack_delay = 2;
        exp_mem(1'b1, 32'h3FE, 32'hDEADBEEF);
        exp_wb(1'b1, 32'h3FE, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4);
        issue(2'd0, 32'hDEADBEEF, 32'h0, 5'd0, 32'h3FF, 1'b0);
        drain();

        // POP with zero-wait ack
        ack_delay = 0;
        rd_value  = 32'h12345678;
        exp_mem(1'b0, 32'h3FE, 32'h0);
        exp_wb(1'b1, 32'h3FF, 1'b1, 5'd5, 32'h12345678, 1'b0, 32'h0, 1'b0, 2);
        issue(2'd1, 32'h0, 32'h0, 5'd5, 32'h3FE, 1'b0);
        drain();

        // CALL then RET
        exp_mem(1'b1, 32'h3FE, 32'h40);
        exp_wb(1'b1, 32'h3FE, 1'b0, 5'd0, 32'h0, 1'b1, 32'h100, 1'b0, 2);
        issue(2'd2, 32'h40, 32'h100, 5'd0, 32'h3FF, 1'b0);
        drain();
        rd_value = 32'h40;
        exp_mem(1'b0, 32'h3FE, 32'h0);
        exp_wb(1'b1, 32'h3FF, 1'b0, 5'd0, 32'h0, 1'b1, 32'h40, 1'b0, 2);
        issue(2'd3, 32'h0, 32'h0, 5'd0, 32'h3FE, 1'b0);
        drain();

        // Reset during MEM of a PUSH, ack arriving after the reset edge
        resp_en = 1'b0;
        manual_ack = 1'b0;
        issue(2'd0, 32'hCAFEF00D, 32'h0, 5'd0, 32'h3FF, 1'b0);
        @(negedge clk);
        chk("mid_mem_req", 64'(mem_req), 64'd1);
        chk("mid_busy_ready", 64'({cmd_ready, read_sp}), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        manual_ack = 1'b1;
        @(negedge clk);
        chk("abort_mem_req", 64'(mem_req), 64'd0);
        chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("abort_no_wb", 64'({write_sp, done}), 64'd0);
        @(posedge clk);
        #1;
        manual_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_ignored", 64'({mem_req, write_sp, done}), 64'd0);
        @(posedge clk);
        #1;
        resp_en = 1'b1;

        // Three back-to-back commands with cmd_valid held high throughout
        rd_value = 32'hA5A5A5A5;
        exp_mem(1'b1, 32'h3FE, 32'h11);
        exp_wb(1'b1, 32'h3FE, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 2);
        exp_mem(1'b1, 32'h3FD, 32'h22);
        exp_wb(1'b1, 32'h3FD, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 2);
        exp_mem(1'b0, 32'h3FD, 32'h0);
        exp_wb(1'b1, 32'h3FE, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0, 2);
        issue(2'd0, 32'h11, 32'h0, 5'd0, 32'h3FF, 1'b1);
        issue(2'd0, 32'h22, 32'h0, 5'd0, 32'h3FE, 1'b1);
        issue(2'd1, 32'h0, 32'h0, 5'd7, 32'h3FD, 1'b0);
        drain();

        // PUSH just above the limit is legal in either build
        exp_mem(1'b1, 32'h300, 32'h99);
        exp_wb(1'b1, 32'h300, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 2);
        issue(2'd0, 32'h99, 32'h0, 5'd0, 32'h301, 1'b0);
        drain();

`ifdef STACK_BOUNDS_CHECK_EN
        // Underflow and overflow: fault/done one cycle after accept, no memory access
        exp_wb(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1);
        issue(2'd1, 32'h0, 32'h0, 5'd3, 32'h3FF, 1'b0);
        drain();
        exp_wb(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1);
        issue(2'd0, 32'h55, 32'h0, 5'd0, 32'h300, 1'b0);
        drain();
        exp_wb(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1);
        issue(2'd2, 32'h8, 32'h200, 5'd0, 32'h0, 1'b0);
        drain();
        exp_wb(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1);
        issue(2'd3, 32'h0, 32'h0, 5'd0, 32'h3FF, 1'b0);
        drain();
`else
        // Without bounds checking SP arithmetic wraps freely
        exp_mem(1'b1, 32'hFFFFFFFF, 32'h55);
        exp_wb(1'b1, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 2);
        issue(2'd0, 32'h55, 32'h0, 5'd0, 32'h0, 1'b0);
        drain();
        rd_value = 32'h77;
        exp_mem(1'b0, 32'h3FF, 32'h0);
        exp_wb(1'b1, 32'h400, 1'b1, 5'd31, 32'h77, 1'b0, 32'h0, 1'b0, 2);
        issue(2'd1, 32'h0, 32'h0, 5'd31, 32'h3FF, 1'b0);
        drain();
`endif

        repeat (3) @(negedge clk);
        chk("memq_empty", 64'(memq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_engine.md
Name: stack_engine

Overview:
- Multi-cycle sequencer for stack instructions PUSH, POP, CALL and RET.
- Sits between decode/control and the register bank.
- Reads the stack pointer through the register bank's SP read path and performs the data-memory access.
- Returns results as one-cycle write strobes: SP write port, general register write port, and a PC load to fetch.

Parameters:
- DATA_W, 32, width of data, SP, PC and memory address.
- SP_STEP, 1, amount SP moves per push/pop (word addressing).
- STACK_BASE, 32'h000003FF, SP value of an empty stack (top).
- STACK_LIMIT, 32'h00000300, lowest legal stack address (used only by the optional feature).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command; high only in IDLE.
- cmd_op  in  2  operation: 0 PUSH, 1 POP, 2 CALL, 3 RET.
- cmd_data  in  DATA_W  PUSH: value to store; CALL: return address.
- cmd_target  in  DATA_W  CALL: jump target.
- cmd_dr  in  5  POP: destination register.
- sp_in  in  DATA_W  current SP from the register bank.
- read_sp  out  1  selects the SP onto the bank read port; high in IDLE.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  DATA_W  memory address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- mem_ack  in  1  completes the request.
- write_sp  out  1  SP write strobe.
- sp_out  out  DATA_W  new SP value.
- write_reg  out  1  GPR write strobe (POP only).
- reg_dr  out  5  destination register.
- reg_data  out  DATA_W  GPR write data.
- pc_load  out  1  PC load strobe (CALL/RET).
- pc_out  out  DATA_W  new PC.
- done  out  1  one-cycle completion pulse.
- fault  out  1  bounds fault pulse (optional feature; else constant 0).

Behaviour:
- States: IDLE, MEM, WB.
- Reset:
  - state IDLE.
  - All strobes low: mem_req, write_sp, write_reg, pc_load, done, fault.
  - All data/address outputs 0.
  - cmd_ready=1, read_sp=1.
- Reset mid-operation: abandons the command next edge. mem_req drops, no write strobes are issued, and a late mem_ack is ignored.
- IDLE:
  - On cmd_valid & cmd_ready, latch op, cmd_data, cmd_target, cmd_dr and sp_in; go to MEM.
  - Otherwise stay in IDLE.
- Address and data computed at accept:
  - PUSH/CALL: new_sp = sp_in − SP_STEP; mem_addr = new_sp; mem_we=1.
    - PUSH: mem_wdata = cmd_data.
    - CALL: mem_wdata = cmd_data (return address).
  - POP/RET: mem_addr = sp_in; mem_we=0; new_sp = sp_in + SP_STEP.
  - Arithmetic is modulo 2^DATA_W (wraps) when the optional feature is off.
- MEM:
  - mem_req=1; mem_addr, mem_we and mem_wdata are held stable until mem_ack.
  - On the mem_ack cycle, capture mem_rdata and go to WB; mem_req is low the following cycle.
  - Zero-wait ack (ack in the first MEM cycle) is legal.
- WB (exactly one cycle):
  - write_sp=1, sp_out=new_sp, done=1.
  - POP: write_reg=1, reg_dr=latched dr, reg_data=captured rdata.
  - CALL: pc_load=1, pc_out=cmd_target.
  - RET: pc_load=1, pc_out=captured rdata.
  - Next state IDLE.
- Latency: accept edge → MEM for (ack wait + 1) cycles → WB. Minimum accept-to-done is 2 cycles; throughput is one command per 3 cycles minimum.
- cmd_valid while busy: ignored (cmd_ready=0); the command must be held by the source.
- All strobes are single-cycle and registered; no strobe is asserted outside WB, except fault.

Optional Feature:
- Macro: STACK_BOUNDS_CHECK_EN.
- Defined: the check happens at accept.
  - PUSH/CALL with sp_in − SP_STEP < STACK_LIMIT (including wrap below 0) is overflow.
  - POP/RET with sp_in + SP_STEP > STACK_BASE is underflow.
  - On a fault: no MEM phase and no write_sp/write_reg/pc_load. Next cycle fault=1 and done=1 for one cycle, then IDLE (state WB reused with strobes suppressed).
- Undefined: no checks, fault tied 0, arithmetic wraps.

Test Plan:
- Reset, then PUSH data=0xDEADBEEF with sp_in=0x3FF, ack after 2 cycles → mem write addr 0x3FE data 0xDEADBEEF; WB: write_sp=1, sp_out=0x3FE, done=1.
- POP dr=5 with sp_in=0x3FE, zero-wait ack with rdata=0x12345678 → mem read addr 0x3FE; WB: write_reg=1, reg_dr=5, reg_data=0x12345678, sp_out=0x3FF; accept-to-done is 2 cycles.
- CALL data=0x40, target=0x100, sp_in=0x3FF → mem write addr 0x3FE data 0x40; WB: pc_load=1, pc_out=0x100, sp_out=0x3FE. Then RET with sp_in=0x3FE, rdata=0x40 → pc_out=0x40, sp_out=0x3FF.
- Assert reset during MEM of a PUSH, then send ack the next cycle → mem_req low after the reset edge; no write_sp/done; cmd_ready=1.
- Hold cmd_valid continuously with 3 back-to-back commands → each is accepted only in IDLE; exactly 3 done pulses, no lost or duplicated commands.
- With STACK_BOUNDS_CHECK_EN: POP at sp_in=0x3FF → fault=1, done=1, no mem_req, no writes. PUSH at sp_in=0x300 → fault. PUSH at sp_in=0x301 → normal, addr 0x300.
